// File: rtl/dmux_route_ctrl_if.sv
// Request handshake and demux drive bundle for dmux_route_ctrl.
// The master issues routing requests; the slave is the sequencer driving the demux.
interface dmux_route_ctrl_if #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned LEN_W = 4
) ();
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_chan;
    logic [LEN_W-1:0] req_len;
    logic             scan_en;
    logic [SEL_W-1:0] sel;
    logic             dmux_in;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_chan, req_len, scan_en,
        input  req_ready, sel, dmux_in, busy, done
    );

    modport slave (
        input  req_valid, req_chan, req_len, scan_en,
        output req_ready, sel, dmux_in, busy, done
    );
endinterface

// File: rtl/dmux_route_ctrl.sv
// Sequencer for a downstream 3-to-8 demux: select settle -> data pulse -> guard,
// so the demux select never moves while its data input is high.
module dmux_route_ctrl #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned GUARD = 1
) (
    input  logic             clk,
    input  logic             rst,
    dmux_route_ctrl_if.slave bus
);
    localparam int unsigned GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam int unsigned CNT_W = (LEN_W > GRD_W) ? LEN_W : GRD_W;
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StDrive, StHold} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             scan_q, scan_d;
    logic             dmux_in_q, dmux_in_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            scan_q    <= 1'b0;
            dmux_in_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            scan_q    <= scan_d;
            dmux_in_q <= dmux_in_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        scan_d  = scan_q;
        unique case (state_q)
            StIdle: begin
                // External requests win over the autonomous scan.
                if (bus.req_valid) begin
                    sel_d   = bus.req_chan;
                    len_d   = bus.req_len;
                    scan_d  = 1'b0;
                    cnt_d   = GUARD_CNT;
                    state_d = StSetup;
                end else if (bus.scan_en) begin
                    sel_d   = ptr_q;
                    len_d   = LEN_W'(1);
                    scan_d  = 1'b1;
                    cnt_d   = GUARD_CNT;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (len_q != '0) begin
                    cnt_d   = CNT_W'(len_q) - CNT_W'(1);
                    state_d = StDrive;
                end else begin
                    cnt_d   = GUARD_CNT;
                    state_d = StHold;
                end
            end
            StDrive: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d   = GUARD_CNT;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = StIdle;
                    if (scan_q) begin
                        ptr_d = ptr_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Outputs are registered from the next state so they align with it.
        dmux_in_d = (state_d == StDrive);
        done_d    = (state_d == StHold) && (cnt_d == '0);
    end

    assign bus.req_ready = (state_q == StIdle) & ~rst;
    assign bus.busy      = (state_q != StIdle);
    assign bus.sel       = sel_q;
    assign bus.dmux_in   = dmux_in_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_dmux_route_ctrl.sv
// Directed self-checking bench for dmux_route_ctrl (GUARD=1, default widths).
// Observed vector per cycle is {sel, dmux_in, done, busy, req_ready}.
module tb_dmux_route_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dmux_route_ctrl_if #(.SEL_W(3), .LEN_W(4)) bus ();

    dmux_route_ctrl #(.SEL_W(3), .LEN_W(4), .GUARD(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] obs();
        return {bus.sel, bus.dmux_in, bus.done, bus.busy, bus.req_ready};
    endfunction

    task automatic test_reset();
        logic [6:0] o;
        #2;
        o = obs();
        checks++;
        if (o !== 7'b000_0000) begin
            errors++;
            $display("FAIL reset_state: got %b, expected %b", o, 7'b000_0000);
        end
        step();
        step();
        rst = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== 7'b000_0001) begin
            errors++;
            $display("FAIL reset_release: got %b, expected %b", o, 7'b000_0001);
        end
    endtask

    task automatic test_single();
        logic [6:0] din, dn, bsy, rdy, o, e;
        din = 7'b0011100;
        dn  = 7'b0100000;
        bsy = 7'b0111110;
        rdy = 7'b1000000;
        bus.req_valid = 1'b1;
        bus.req_chan  = 3'd5;
        bus.req_len   = 4'd3;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) begin
                bus.req_valid = 1'b0;
                bus.req_chan  = 3'd0;
                bus.req_len   = 4'd0;
            end
            o = obs();
            e = {3'd5, din[c], dn[c], bsy[c], rdy[c]};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single cycle %0d: got %b, expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_len0();
        logic [3:0] dn, bsy, rdy;
        logic [6:0] o, e;
        dn  = 4'b0100;
        bsy = 4'b0110;
        rdy = 4'b1000;
        bus.req_valid = 1'b1;
        bus.req_chan  = 3'd2;
        bus.req_len   = 4'd0;
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.req_valid = 1'b0;
            o = obs();
            e = {3'd2, 1'b0, dn[c], bsy[c], rdy[c]};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL len0 cycle %0d: got %b, expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] din, dn, bsy, rdy;
        logic [6:0] o, e;
        logic [2:0] prev_sel, exp_sel;
        logic       prev_din;
        int         viol;
        din = 10'b0010001100;
        dn  = 10'b0100010000;
        bsy = 10'b0111011110;
        rdy = 10'b1000100000;
        viol = 0;
        prev_sel = bus.sel;
        prev_din = bus.dmux_in;
        bus.req_valid = 1'b1;
        bus.req_chan  = 3'd1;
        bus.req_len   = 4'd2;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) begin
                bus.req_chan = 3'd6;
                bus.req_len  = 4'd1;
            end
            if (c == 6) bus.req_valid = 1'b0;
            o = obs();
            exp_sel = (c <= 5) ? 3'd1 : 3'd6;
            e = {exp_sel, din[c], dn[c], bsy[c], rdy[c]};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b cycle %0d: got %b, expected %b", c, o, e);
            end
            if (bus.sel != prev_sel && (bus.dmux_in || prev_din)) viol++;
            prev_sel = bus.sel;
            prev_din = bus.dmux_in;
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL b2b_sel_while_high: got %0d, expected 0", viol);
        end
    endtask

    task automatic test_scan();
        logic [8:0] din, dn, bsy, rdy;
        logic [6:0] o, e;
        logic [2:0] exp_sel;
        int         ph;
        bus.scan_en = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            step();
            ph = (c - 1) % 4;
            exp_sel = 3'(((c - 1) / 4) % 8);
            e = {exp_sel, ph == 1, ph == 2, ph != 3, ph == 3};
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL scan cycle %0d: got %b, expected %b", c, o, e);
            end
        end
        // Scan is idle with ptr=4; an external request must go first.
        bus.req_valid = 1'b1;
        bus.req_chan  = 3'd3;
        bus.req_len   = 4'd1;
        din = 9'b000100010;
        dn  = 9'b001000100;
        bsy = 9'b001110111;
        rdy = 9'b110001000;
        for (int i = 0; i <= 8; i++) begin
            step();
            if (i == 0) bus.req_valid = 1'b0;
            if (i == 4) bus.scan_en = 1'b0;
            exp_sel = (i < 4) ? 3'd3 : 3'd4;
            e = {exp_sel, din[i], dn[i], bsy[i], rdy[i]};
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL scan_preempt cycle %0d: got %b, expected %b", 81 + i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] o;
        logic [6:0] exp_post [5];
        exp_post[0] = 7'b000_0001;
        exp_post[1] = 7'b000_0010;
        exp_post[2] = 7'b000_1010;
        exp_post[3] = 7'b000_0110;
        exp_post[4] = 7'b000_0001;
        bus.req_valid = 1'b1;
        bus.req_chan  = 3'd4;
        bus.req_len   = 4'd8;
        for (int c = 1; c <= 4; c++) begin
            step();
            bus.req_valid = 1'b0;
        end
        o = obs();
        checks++;
        if (o !== 7'b100_1010) begin
            errors++;
            $display("FAIL rstmid_drive: got %b, expected %b", o, 7'b100_1010);
        end
        rst = 1'b1;
        bus.scan_en = 1'b1;
        #1;
        o = obs();
        checks++;
        if (o !== 7'b000_0000) begin
            errors++;
            $display("FAIL rstmid_async: got %b, expected %b", o, 7'b000_0000);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            o = obs();
            checks++;
            if (o !== 7'b000_0000) begin
                errors++;
                $display("FAIL rstmid_held cycle %0d: got %b, expected %b", c, o, 7'b000_0000);
            end
        end
        rst = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) step();
            if (c == 1) bus.scan_en = 1'b0;
            if (c == 0) #1;
            o = obs();
            checks++;
            if (o !== exp_post[c]) begin
                errors++;
                $display("FAIL rstmid_post cycle %0d: got %b, expected %b", c, o, exp_post[c]);
            end
        end
    endtask

    task automatic test_max_len();
        int highs, first_high, done_cyc;
        logic [2:0] sel1;
        logic       rdy_end;
        highs = 0;
        first_high = -1;
        done_cyc = -1;
        sel1 = 3'd0;
        rdy_end = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_chan  = 3'd7;
        bus.req_len   = 4'd15;
        for (int c = 1; c <= 18; c++) begin
            step();
            bus.req_valid = 1'b0;
            if (c == 1) sel1 = bus.sel;
            if (bus.dmux_in) begin
                highs++;
                if (first_high < 0) first_high = c;
            end
            if (bus.done) done_cyc = c;
            if (c == 18) rdy_end = bus.req_ready;
        end
        checks++;
        if (highs !== 15) begin
            errors++;
            $display("FAIL maxlen_highs: got %0d, expected 15", highs);
        end
        checks++;
        if (first_high !== 2) begin
            errors++;
            $display("FAIL maxlen_first_high: got %0d, expected 2", first_high);
        end
        checks++;
        if (done_cyc !== 17) begin
            errors++;
            $display("FAIL maxlen_done_cycle: got %0d, expected 17", done_cyc);
        end
        checks++;
        if (sel1 !== 3'd7) begin
            errors++;
            $display("FAIL maxlen_sel: got %0d, expected 7", sel1);
        end
        checks++;
        if (rdy_end !== 1'b1) begin
            errors++;
            $display("FAIL maxlen_ready: got %0d, expected 1", rdy_end);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_chan  = 3'd0;
        bus.req_len   = 4'd0;
        bus.scan_en   = 1'b0;
        test_reset();
        test_single();
        test_len0();
        test_back_to_back();
        test_scan();
        test_reset_mid();
        test_max_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
